// File: rtl/alarm_clk_rtc_if.sv
`default_nettype none
// ============================================================================
//  Module  : alarm_clk_rtc_if
//  Brief   : Avalon-MM slave bus bundle for the alarm clock / RTC block.
//  Rev     : 1.0  initial release
// ============================================================================
interface alarm_clk_rtc_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/alarm_clk_rtc.sv
`default_nettype none
// ============================================================================
//  Module  : alarm_clk_rtc
//  Brief   : BCD time-of-day clock with alarm, interrupt and Avalon-MM access.
//  Rev     : 1.0  initial release
// ============================================================================
module alarm_clk_rtc #(
   parameter int PRESCALE  = 1,
   parameter int ALARM_DUR = 60
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            tick,
   alarm_clk_rtc_if.slave  bus,
   output logic            irq,
   output logic            alarm_active,
   output logic            sec_pulse
);

   localparam logic [7:0] PRESCALE_MAX = 8'(PRESCALE - 1);
   localparam logic [7:0] ALARM_DUR_C  = 8'(ALARM_DUR);

   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
   endfunction

   // Returns {wrap, next}; wrap means the digit pair rolled over to 00.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)           return 9'h100;
      else if (v[3:0] == 4'd9)  return {1'b0, v[7:4] + 4'd1, 4'd0};
      else                      return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

   logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   logic [15:0] alarm_hm_q, alarm_hm_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [7:0]  presc_q, presc_d, cnt_q, cnt_d;
   logic        alarm_flag_q, alarm_flag_d, sec_flag_q, sec_flag_d;
   logic        alarm_active_q, alarm_active_d, wr_err_q, wr_err_d;
   logic        sec_pulse_q, sec_pulse_d;
   logic [15:0] readdata_q, readdata_d;

   logic        we, wr_hm, wr_s, wr_alm, wr_ctrl, wr_stat;
   logic        hm_ok, s_ok, time_load, presc_hit, adv, match;
   logic [15:0] wd;
   logic [8:0]  ss_inc, mm_inc, hh_inc;
   logic [7:0]  nxt_ss, nxt_mm, nxt_hh;

   always_comb begin
      we        = bus.chipselect & ~bus.write_n;
      wd        = bus.writedata;
      wr_hm     = we & (bus.address == 3'd0);
      wr_s      = we & (bus.address == 3'd1);
      wr_alm    = we & (bus.address == 3'd2);
      wr_ctrl   = we & (bus.address == 3'd3);
      wr_stat   = we & (bus.address == 3'd4);
      hm_ok     = bcd_ok(wd[15:8], 8'h23) & bcd_ok(wd[7:0], 8'h59);
      s_ok      = bcd_ok(wd[7:0], 8'h59);
      time_load = (wr_hm & hm_ok) | (wr_s & s_ok);
      presc_hit = ctrl_q[0] & tick & (presc_q == PRESCALE_MAX);
      // A valid time write overrides a coincident advance.
      adv       = presc_hit & ~time_load;

      ss_inc = bcd_inc(ss_q, 8'h59);
      mm_inc = bcd_inc(mm_q, 8'h59);
      hh_inc = bcd_inc(hh_q, 8'h23);
      nxt_ss = ss_inc[7:0];
      nxt_mm = ss_inc[8] ? mm_inc[7:0] : mm_q;
      nxt_hh = (ss_inc[8] & mm_inc[8]) ? hh_inc[7:0] : hh_q;
      match  = adv & ctrl_q[1] & (nxt_ss == 8'h00) & ({nxt_hh, nxt_mm} == alarm_hm_q);

      hh_d           = hh_q;
      mm_d           = mm_q;
      ss_d           = ss_q;
      alarm_hm_d     = alarm_hm_q;
      ctrl_d         = ctrl_q;
      presc_d        = presc_q;
      cnt_d          = cnt_q;
      alarm_flag_d   = alarm_flag_q;
      sec_flag_d     = sec_flag_q;
      alarm_active_d = alarm_active_q;
      wr_err_d       = wr_err_q;
      sec_pulse_d    = adv;

      if (ctrl_q[0] & tick)
         presc_d = presc_hit ? 8'd0 : presc_q + 8'd1;
      if (adv) begin
         hh_d = nxt_hh;
         mm_d = nxt_mm;
         ss_d = nxt_ss;
      end
      if (wr_hm & hm_ok) begin
         hh_d    = wd[15:8];
         mm_d    = wd[7:0];
         ss_d    = 8'h00;
         presc_d = 8'd0;
      end
      if (wr_s & s_ok) begin
         ss_d    = wd[7:0];
         presc_d = 8'd0;
      end
      if (wr_alm & hm_ok)
         alarm_hm_d = wd;
      if (wr_ctrl)
         ctrl_d = wd[3:0];

      if (wr_stat & wd[3])
         wr_err_d = 1'b0;
      if (((wr_hm | wr_alm) & ~hm_ok) | (wr_s & ~s_ok))
         wr_err_d = 1'b1;

      // Clears are applied before sets so a coincident set wins.
      if (wr_stat & wd[1]) sec_flag_d = 1'b0;
      if (adv)             sec_flag_d = 1'b1;
      if (wr_stat & wd[0]) alarm_flag_d = 1'b0;
      if (match)           alarm_flag_d = 1'b1;

      if (adv & alarm_active_q) begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1)
            alarm_active_d = 1'b0;
      end
      if (wr_stat & wd[2])
         alarm_active_d = 1'b0;
      if (match) begin
         alarm_active_d = 1'b1;
         cnt_d          = ALARM_DUR_C;
      end
      if (wr_ctrl & ~wd[1])
         alarm_active_d = 1'b0;

      case (bus.address)
         3'd0:    readdata_d = {hh_q, mm_q};
         3'd1:    readdata_d = {8'h00, ss_q};
         3'd2:    readdata_d = alarm_hm_q;
         3'd3:    readdata_d = {12'h000, ctrl_q};
         3'd4:    readdata_d = {12'h000, wr_err_q, alarm_active_q, sec_flag_q, alarm_flag_q};
         default: readdata_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hh_q           <= 8'h00;
         mm_q           <= 8'h00;
         ss_q           <= 8'h00;
         alarm_hm_q     <= 16'h0000;
         ctrl_q         <= 4'h0;
         presc_q        <= 8'd0;
         cnt_q          <= 8'd0;
         alarm_flag_q   <= 1'b0;
         sec_flag_q     <= 1'b0;
         alarm_active_q <= 1'b0;
         wr_err_q       <= 1'b0;
         sec_pulse_q    <= 1'b0;
         readdata_q     <= 16'h0000;
      end else begin
         hh_q           <= hh_d;
         mm_q           <= mm_d;
         ss_q           <= ss_d;
         alarm_hm_q     <= alarm_hm_d;
         ctrl_q         <= ctrl_d;
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         alarm_flag_q   <= alarm_flag_d;
         sec_flag_q     <= sec_flag_d;
         alarm_active_q <= alarm_active_d;
         wr_err_q       <= wr_err_d;
         sec_pulse_q    <= sec_pulse_d;
         readdata_q     <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign alarm_active = alarm_active_q;
   assign sec_pulse    = sec_pulse_q;
   assign irq          = (alarm_flag_q & ctrl_q[2]) | (sec_flag_q & ctrl_q[3]);

endmodule
`default_nettype wire

// File: tb/tb_alarm_clk_rtc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alarm_clk_rtc
//  Brief   : Two RTC instances (PRESCALE 1 and 4) against a seconds-of-day model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alarm_clk_rtc;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tick = 1'b0;
   always #5 clk = ~clk;

   alarm_clk_rtc_if bus0();
   alarm_clk_rtc_if bus1();

   logic        irq_o [2];
   logic        act_o [2];
   logic        sp_o  [2];
   logic [15:0] rd_o  [2];
   assign rd_o[0] = bus0.readdata;
   assign rd_o[1] = bus1.readdata;

   alarm_clk_rtc #(.PRESCALE(1), .ALARM_DUR(3)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .bus(bus0.slave),
      .irq(irq_o[0]), .alarm_active(act_o[0]), .sec_pulse(sp_o[0])
   );
   alarm_clk_rtc #(.PRESCALE(4), .ALARM_DUR(5)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .tick(tick), .bus(bus1.slave),
      .irq(irq_o[1]), .alarm_active(act_o[1]), .sec_pulse(sp_o[1])
   );

   int c_presc [2] = '{1, 4};
   int c_dur   [2] = '{3, 5};

   int n_tests = 0;
   int n_fail  = 0;
   int sp_cnt [2];

   // model: time kept as plain seconds since midnight
   int          m_tod [2], m_ah [2], m_am [2], m_presc [2], m_cnt [2];
   logic [3:0]  m_ctrl [2];
   bit          m_af [2], m_sf [2], m_act [2], m_werr [2], m_sp [2];
   logic [15:0] m_rd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic int from_bcd(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic bit bcd_valid(input logic [7:0] v, input int max_v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (from_bcd(v) <= max_v);
   endfunction

   function automatic logic [15:0] model_read(input int k, input logic [2:0] a);
      case (a)
         3'd0:    return {bcd(m_tod[k] / 3600), bcd((m_tod[k] / 60) % 60)};
         3'd1:    return {8'h00, bcd(m_tod[k] % 60)};
         3'd2:    return {bcd(m_ah[k]), bcd(m_am[k])};
         3'd3:    return {12'h000, m_ctrl[k]};
         3'd4:    return {12'h000, m_werr[k], m_act[k], m_sf[k], m_af[k]};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step(input int k);
      logic        we;
      logic [2:0]  a;
      logic [15:0] d;
      bit          tload, hit, adv, match, hm_v;
      int          ntod;
      if (!reset_n) begin
         m_tod[k] = 0; m_ah[k] = 0; m_am[k] = 0; m_presc[k] = 0; m_cnt[k] = 0;
         m_ctrl[k] = 4'h0; m_af[k] = 0; m_sf[k] = 0; m_act[k] = 0; m_werr[k] = 0;
         m_sp[k] = 0; m_rd[k] = 16'h0000;
         return;
      end
      a  = bus0.address;
      d  = bus0.writedata;
      we = bus0.chipselect && !bus0.write_n;
      m_rd[k] = model_read(k, a);
      hm_v  = bcd_valid(d[15:8], 23) && bcd_valid(d[7:0], 59);
      tload = we && ((a == 3'd0 && hm_v) || (a == 3'd1 && bcd_valid(d[7:0], 59)));
      hit = 0;
      if (m_ctrl[k][0] && tick) begin
         if (m_presc[k] == c_presc[k] - 1) begin
            m_presc[k] = 0;
            hit = 1;
         end else m_presc[k]++;
      end
      adv   = hit && !tload;
      ntod  = (m_tod[k] + 1) % 86400;
      match = adv && m_ctrl[k][1] && (ntod % 60 == 0) && (ntod / 60 == m_ah[k] * 60 + m_am[k]);
      if (adv) m_tod[k] = ntod;
      if (tload) begin
         m_presc[k] = 0;
         if (a == 3'd0) m_tod[k] = from_bcd(d[15:8]) * 3600 + from_bcd(d[7:0]) * 60;
         else           m_tod[k] = m_tod[k] - (m_tod[k] % 60) + from_bcd(d[7:0]);
      end
      if (we && a == 3'd2) begin
         if (hm_v) begin
            m_ah[k] = from_bcd(d[15:8]);
            m_am[k] = from_bcd(d[7:0]);
         end else m_werr[k] = 1;
      end
      if (we && a <= 3'd1 && !tload) m_werr[k] = 1;
      if (we && a == 3'd4) begin
         if (d[3]) m_werr[k] = 0;
         if (d[1]) m_sf[k] = 0;
         if (d[0]) m_af[k] = 0;
      end
      if (adv) m_sf[k] = 1;
      if (match) m_af[k] = 1;
      if (adv && m_act[k] && !match) begin
         m_cnt[k]--;
         if (m_cnt[k] == 0) m_act[k] = 0;
      end
      if (we && a == 3'd4 && d[2] && !match) m_act[k] = 0;
      if (match) begin
         m_act[k] = 1;
         m_cnt[k] = c_dur[k];
      end
      if (we && a == 3'd3) begin
         m_ctrl[k] = d[3:0];
         if (!d[1]) m_act[k] = 0;
      end
      m_sp[k] = adv;
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("readdata%0d", k), rd_o[k], m_rd[k]);
         chk($sformatf("irq%0d", k), irq_o[k],
             (m_af[k] & m_ctrl[k][2]) | (m_sf[k] & m_ctrl[k][3]));
         chk($sformatf("alarm_active%0d", k), act_o[k], m_act[k]);
         chk($sformatf("sec_pulse%0d", k), sp_o[k], m_sp[k]);
         if (sp_o[k]) sp_cnt[k]++;
      end
   endtask

   task automatic set_bus(input logic [2:0] a, input logic cs, input logic wn, input logic [15:0] d);
      bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = d;
      bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = d;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      set_bus(a, 1'b1, 1'b0, d);
      cycle();
      set_bus(3'd0, 1'b0, 1'b1, 16'h0000);
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] v0, output logic [15:0] v1);
      set_bus(a, 1'b1, 1'b1, 16'h0000);
      cycle();
      v0 = rd_o[0];
      v1 = rd_o[1];
      set_bus(3'd0, 1'b0, 1'b1, 16'h0000);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1'b1; cycle();
         tick = 1'b0; cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v0, v1;
      int ah, am, back, t;
      logic [2:0] ra;
      logic [15:0] rdat;

      set_bus(3'd0, 1'b0, 1'b1, 16'h0000);
      cycle(); cycle();
      reset_n = 1'b1;

      rd(3'd0, v0, v1); chk("rst_time_hm", {v1, v0}, 32'h0);
      rd(3'd1, v0, v1); chk("rst_time_s",  {v1, v0}, 32'h0);
      rd(3'd3, v0, v1); chk("rst_control", {v1, v0}, 32'h0);
      rd(3'd4, v0, v1); chk("rst_status",  {v1, v0}, 32'h0);
      chk("rst_irq", {irq_o[1], irq_o[0]}, 0);
      chk("rst_active", {act_o[1], act_o[0]}, 0);

      // day wrap on the PRESCALE=1 instance
      wr(3'd0, 16'h2359); wr(3'd1, 16'h0058); wr(3'd3, 16'h0001);
      sp_cnt[0] = 0;
      ticks(2);
      chk("wrap_pulses", sp_cnt[0], 2);
      rd(3'd0, v0, v1); chk("wrap_hm", v0, 16'h0000);
      rd(3'd1, v0, v1); chk("wrap_s", v0, 16'h0000);
      rd(3'd4, v0, v1); chk("wrap_sec_flag", v0[1], 1'b1);

      // invalid write
      wr(3'd0, 16'h1A00);
      rd(3'd0, v0, v1); chk("bad_wr_hm", v0, 16'h0000);
      rd(3'd4, v0, v1); chk("bad_wr_err", v0[3], 1'b1);
      wr(3'd4, 16'h0008);
      rd(3'd4, v0, v1); chk("wr_err_w1c", v0[3], 1'b0);

      // alarm ring and countdown
      wr(3'd2, 16'h0701); wr(3'd0, 16'h0700); wr(3'd1, 16'h0059); wr(3'd3, 16'h0007);
      ticks(1);
      chk("alm_active", act_o[0], 1'b1);
      chk("alm_irq", irq_o[0], 1'b1);
      rd(3'd4, v0, v1); chk("alm_flag", v0[0], 1'b1);
      ticks(2);
      chk("alm_still_on", act_o[0], 1'b1);
      ticks(1);
      chk("alm_expired", act_o[0], 1'b0);
      chk("alm_irq_held", irq_o[0], 1'b1);
      wr(3'd4, 16'h0001);
      chk("alm_irq_clr", irq_o[0], 1'b0);

      // dismiss
      wr(3'd0, 16'h0700); wr(3'd1, 16'h0059);
      ticks(1);
      chk("dis_ring", act_o[0], 1'b1);
      wr(3'd4, 16'h0004);
      chk("dis_active", act_o[0], 1'b0);
      rd(3'd4, v0, v1); chk("dis_flag_kept", v0[0], 1'b1);

      // prescaler on the PRESCALE=4 instance, then reset mid-run
      wr(3'd0, 16'h0000); wr(3'd1, 16'h0000); wr(3'd3, 16'h0001);
      ticks(7);
      rd(3'd1, v0, v1); chk("presc_s", v1, 16'h0001);
      reset_n = 1'b0;
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
      reset_n = 1'b1;
      rd(3'd1, v0, v1); chk("presc_rst_s", v1, 16'h0000);
      wr(3'd3, 16'h0001);
      sp_cnt[1] = 0;
      ticks(3);
      chk("presc_no_adv", sp_cnt[1], 0);
      ticks(1);
      chk("presc_adv", sp_cnt[1], 1);

      // randomized scenarios aimed near the alarm time
      for (int s = 0; s < 40; s++) begin
         ah   = $urandom_range(23);
         am   = $urandom_range(59);
         back = $urandom_range(12, 1);
         t    = (ah * 3600 + am * 60 - back + 86400) % 86400;
         wr(3'd2, {bcd(ah), bcd(am)});
         wr(3'd0, {bcd(t / 3600), bcd((t / 60) % 60)});
         wr(3'd1, {8'h00, bcd(t % 60)});
         wr(3'd3, {12'h000, 2'($urandom_range(3)), 2'b11});
         for (int c = 0; c < 80; c++) begin
            tick = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) begin
               ra = 3'($urandom_range(7));
               if (ra == 3'd3)            rdat = {12'h000, 4'($urandom) | 4'h1};
               else if ($urandom_range(1)) rdat = {bcd($urandom_range(29)), bcd($urandom_range(69))};
               else                       rdat = 16'($urandom);
               set_bus(ra, 1'b1, 1'($urandom_range(1)), rdat);
            end else begin
               set_bus(3'($urandom_range(7)), 1'b0, 1'b1, 16'h0000);
            end
            cycle();
         end
         tick = 1'b0;
         set_bus(3'd0, 1'b0, 1'b1, 16'h0000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
